// File: rtl/field_serializer_pkg.sv
// Shared types, wire-type codes and helper functions for the protobuf field serializer.
package field_serializer_pkg;

  // Protobuf wire types handled (or recognised) by the serializer.
  localparam logic [2:0] WT_VARINT  = 3'd0;
  localparam logic [2:0] WT_FIXED64 = 3'd1;
  localparam logic [2:0] WT_LEN     = 3'd2;
  localparam logic [2:0] WT_FIXED32 = 3'd5;

  // One field descriptor as delivered by the object buffer.
  typedef struct packed {
    logic [28:0] field_id;
    logic [2:0]  wire_type;
    logic [3:0]  size_bytes;
    logic [31:0] offset;
    logic        nested;
  } table_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TAG      = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_VALUE    = 3'd4,
    ST_DONE     = 3'd5
  } ser_state_e;

  // Protobuf key: field number shifted over the 3-bit wire type.
  function automatic logic [63:0] make_tag(input logic [28:0] field_id, input logic [2:0] wire_type);
    return {32'd0, field_id, wire_type};
  endfunction

  // Wire types whose value is fetched from memory and emitted here.
  function automatic logic wt_has_value(input logic [2:0] wire_type);
    return (wire_type == WT_VARINT) || (wire_type == WT_FIXED64) || (wire_type == WT_FIXED32);
  endfunction

  // Keep only the bytes of the C++ scalar; never sign-extend.
  function automatic logic [63:0] mask_to_size(input logic [63:0] value, input logic [3:0] size_bytes);
    logic [63:0] masked;
    case (size_bytes)
      4'd1:    masked = {56'd0, value[7:0]};
      4'd2:    masked = {48'd0, value[15:0]};
      4'd4:    masked = {32'd0, value[31:0]};
      default: masked = value;
    endcase
    return masked;
  endfunction

endpackage

// File: rtl/field_serializer_varint_emitter.sv
// Byte emitter: varint (7 bits per byte, continuation in bit 7) or fixed-width little-endian.
module field_serializer_varint_emitter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [63:0] load_value,
  input  logic        load_fixed,
  input  logic [3:0]  load_nbytes,
  input  logic        load_final,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        out_last,
  output logic        byte_done
);

  logic [63:0] val_r, val_nx_s;
  logic        fixed_r, fixed_nx_s;
  logic [3:0]  cnt_r, cnt_nx_s;
  logic        final_r, final_nx_s;
  logic        valid_nx_s;
  logic [7:0]  byte_nx_s;
  logic        last_nx_s;
  logic [7:0]  out_byte_r;
  logic        out_valid_r, out_last_r, seg_last_r;
  logic        accept_s;

  assign accept_s  = out_valid_r & out_ready;
  assign byte_done = accept_s & seg_last_r;
  assign out_byte  = out_byte_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

  // Next shift-register contents: load a new value or consume the accepted byte.
  always_comb begin
    val_nx_s   = val_r;
    fixed_nx_s = fixed_r;
    cnt_nx_s   = cnt_r;
    final_nx_s = final_r;
    valid_nx_s = out_valid_r;
    if (load) begin
      val_nx_s   = load_value;
      fixed_nx_s = load_fixed;
      cnt_nx_s   = load_nbytes;
      final_nx_s = load_final;
      valid_nx_s = 1'b1;
    end else if (accept_s) begin
      if (seg_last_r) begin
        valid_nx_s = 1'b0;
      end else begin
        if (fixed_r) begin
          val_nx_s = {8'd0, val_r[63:8]};
        end else begin
          val_nx_s = {7'd0, val_r[63:7]};
        end
        cnt_nx_s = cnt_r - 4'd1;
      end
    end else begin
      valid_nx_s = out_valid_r;
    end
  end

  // Byte output mux shared by the varint and fixed-width encodings.
  always_comb begin
    byte_nx_s = 8'd0;
    last_nx_s = 1'b0;
    if (fixed_nx_s) begin
      byte_nx_s = val_nx_s[7:0];
      last_nx_s = (cnt_nx_s <= 4'd1);
    end else begin
      byte_nx_s = {(val_nx_s[63:7] != 57'd0), val_nx_s[6:0]};
      last_nx_s = (val_nx_s[63:7] == 57'd0);
    end
  end

  // Registered byte stream; byte and flags only move on load or acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_r       <= 64'd0;
      fixed_r     <= 1'b0;
      cnt_r       <= 4'd0;
      final_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'd0;
      out_last_r  <= 1'b0;
      seg_last_r  <= 1'b0;
    end else begin
      val_r       <= val_nx_s;
      fixed_r     <= fixed_nx_s;
      cnt_r       <= cnt_nx_s;
      final_r     <= final_nx_s;
      out_valid_r <= valid_nx_s;
      if (valid_nx_s) begin
        out_byte_r <= byte_nx_s;
        seg_last_r <= last_nx_s;
        out_last_r <= last_nx_s & final_nx_s;
      end else begin
        seg_last_r <= 1'b0;
        out_last_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/field_serializer.sv
// Serializes one table entry: tag varint, memory fetch of the scalar, then its wire encoding.
module field_serializer
  import field_serializer_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  table_entry_t      in_entry,
  input  logic              in_entry_valid,
  input  logic [ADDR_W-1:0] cpp_base_addr,
  output logic              ser_ready,
  output logic              ser_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              err
);

  ser_state_e        state_r, state_nx_s;
  logic              accept_s;
  logic [2:0]        wt_r;
  logic [3:0]        size_r;
  logic [31:0]       offset_r;
  logic              nested_r;
  logic [ADDR_W-1:0] base_r;
  logic              unsupported_s;
  logic [63:0]       rdata_s;
  logic              em_load_s, em_fixed_s, em_final_s, em_done_s;
  logic [63:0]       em_value_s;
  logic [3:0]        em_nbytes_s;
  logic              ser_ready_r, ser_done_r, mem_req_r, err_r;
  logic [ADDR_W-1:0] mem_addr_r;

  assign rdata_s       = 64'(mem_rdata);
  assign unsupported_s = !nested_r && !wt_has_value(wt_r);
  assign ser_ready     = ser_ready_r;
  assign ser_done      = ser_done_r;
  assign mem_req       = mem_req_r;
  assign mem_addr      = mem_addr_r;
  assign err           = err_r;

  // Next state and emitter load commands.
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 1'b0;
    em_load_s   = 1'b0;
    em_value_s  = 64'd0;
    em_fixed_s  = 1'b0;
    em_nbytes_s = 4'd0;
    em_final_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_entry_valid && ser_ready_r) begin
          accept_s = 1'b1;
          if (in_entry.field_id == 29'd0) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_TAG;
            em_load_s  = 1'b1;
            em_value_s = make_tag(in_entry.field_id, in_entry.wire_type);
            // The tag ends the entry when no value follows it.
            em_final_s = in_entry.nested || !wt_has_value(in_entry.wire_type);
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_TAG: begin
        if (em_done_s) begin
          if (nested_r || unsupported_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_MEM_REQ;
          end
        end else begin
          state_nx_s = ST_TAG;
        end
      end
      ST_MEM_REQ: begin
        if (mem_gnt) begin
          state_nx_s = ST_MEM_WAIT;
        end else begin
          state_nx_s = ST_MEM_REQ;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_rvalid) begin
          state_nx_s = ST_VALUE;
          em_load_s  = 1'b1;
          em_final_s = 1'b1;
          case (wt_r)
            WT_FIXED64: begin
              em_value_s  = rdata_s;
              em_fixed_s  = 1'b1;
              em_nbytes_s = 4'd8;
            end
            WT_FIXED32: begin
              em_value_s  = {32'd0, rdata_s[31:0]};
              em_fixed_s  = 1'b1;
              em_nbytes_s = 4'd4;
            end
            default: begin
              em_value_s = mask_to_size(rdata_s, size_r);
            end
          endcase
        end else begin
          state_nx_s = ST_MEM_WAIT;
        end
      end
      ST_VALUE: begin
        if (em_done_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_VALUE;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register and registered control outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      ser_ready_r <= 1'b1;
      ser_done_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      ser_ready_r <= (state_nx_s == ST_IDLE);
      ser_done_r  <= (state_nx_s == ST_DONE);
      mem_req_r   <= (state_nx_s == ST_MEM_REQ);
      err_r       <= (state_r == ST_TAG) && em_done_s && unsupported_s;
    end
  end

  // Entry latch on acceptance; read address computed once and held through the request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wt_r       <= 3'd0;
      size_r     <= 4'd0;
      offset_r   <= 32'd0;
      nested_r   <= 1'b0;
      base_r     <= '0;
      mem_addr_r <= '0;
    end else begin
      if (accept_s) begin
        wt_r     <= in_entry.wire_type;
        size_r   <= in_entry.size_bytes;
        offset_r <= in_entry.offset;
        nested_r <= in_entry.nested;
        base_r   <= cpp_base_addr;
      end
      if ((state_nx_s == ST_MEM_REQ) && (state_r != ST_MEM_REQ)) begin
        mem_addr_r <= base_r + ADDR_W'(offset_r);
      end
    end
  end

  field_serializer_varint_emitter u_emitter (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (em_load_s),
    .load_value  (em_value_s),
    .load_fixed  (em_fixed_s),
    .load_nbytes (em_nbytes_s),
    .load_final  (em_final_s),
    .out_ready   (out_ready),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .byte_done   (em_done_s)
  );

endmodule

// File: doc/field_serializer.md
Name: field_serializer

Overview:
Consumer end of the object buffer's serializer interface. It accepts one TABLE_ENTRY at a time, fetches the scalar field from C++ object memory at cpp_base_addr + offset, and emits the protobuf wire encoding (tag varint, then the value) as a byte stream. It pulses ser_done so the buffer advances to the next entry.

Parameters:
ADDR_W, 64, object memory address width (matches cpp_base_addr)
DATA_W, 64, memory read data width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
in_entry  in  TABLE_ENTRY  entry from object buffer
in_entry_valid  in  1  entry valid
cpp_base_addr  in  ADDR_W  base address of the current C++ object
ser_ready  out  1  serializer idle, can accept an entry
ser_done  out  1  one-cycle pulse: entry fully serialized
mem_req  out  1  read request
mem_addr  out  ADDR_W  read address
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
out_byte  out  8  encoded byte
out_valid  out  1  out_byte valid
out_ready  in  1  downstream accepts byte
out_last  out  1  last byte of this entry
err  out  1  one-cycle pulse: unsupported wire type

Behaviour:
- Reset (async, reset_n=0): state IDLE. ser_done, mem_req, out_valid, out_last and err are 0. mem_addr and out_byte are 0. ser_ready is 1 once reset is released.
- States: IDLE, TAG, MEM_REQ, MEM_WAIT, VALUE, DONE.
- IDLE:
  - ser_ready=1.
  - Accept when in_entry_valid & ser_ready. On acceptance, latch the entry and cpp_base_addr, and load the tag (field_id<<3 | wire_type) into the varint emitter.
  - field_id==0 (end-of-message) goes straight to DONE with no bytes and no mem_req.
  - Otherwise go to TAG.
- TAG: emits the tag varint.
  - Each byte carries the low 7 bits; bit7 is set if the remaining value is nonzero. Shift right by 7 per accepted byte (out_valid & out_ready).
  - After the last tag byte: nested → DONE (length prefix is out of scope here); otherwise → MEM_REQ.
- Unsupported wire type: wire_type not in {0,1,5} and not nested. Tag bytes are still emitted, then err pulses with ser_done.
- MEM_REQ:
  - mem_req=1, mem_addr = latched base + offset, 64-bit modulo wrap.
  - mem_req is held until mem_gnt; on mem_gnt → MEM_WAIT.
  - mem_addr is stable while mem_req=1.
- MEM_WAIT: capture mem_rdata on mem_rvalid → VALUE.
- VALUE, by wire type:
  - wire_type 0 (VARINT): value is masked to size_bytes (1/2/4/8) and zero-extended; no sign extension. Emitted as a varint of 1–10 bytes; value 0 emits the single byte 0x00.
  - wire_type 1 (FIXED64): 8 bytes, little-endian.
  - wire_type 5 (FIXED32): 4 bytes, little-endian, low word.
  - out_last is asserted on the final byte; → DONE after it is accepted.
- DONE: ser_done=1 for exactly one cycle, ser_ready=0 → IDLE.
- Output handshake:
  - out_byte and out_last are stable while out_valid & !out_ready.
  - out_valid is never withdrawn before acceptance.
  - No bytes are emitted outside TAG/VALUE.
- ser_ready is 0 in every state except IDLE. An entry presented while busy is ignored, never latched.
- Latency for a 1-byte tag, 1-byte value, zero-wait memory: accept at cycle A → tag byte valid at A+1 → mem_req at A+2 → ser_done no earlier than A+5.
- A mem_rvalid arriving outside MEM_WAIT (e.g. stale, after reset) is ignored.
- Reset mid-operation: immediate return to IDLE and all outputs to reset values; the in-flight entry is dropped.

Decomposition:
- Shared package (alongside TABLE_ENTRY / BUFFER_ENTRY) holds:
  - wire-type localparams: WT_VARINT=0, WT_FIXED64=1, WT_LEN=2, WT_FIXED32=5;
  - the serializer state enum;
  - TABLE_ENTRY fields used: field_id, wire_type, size_bytes, offset, nested.
- One sub-module, varint_emitter: load value, byte/valid/ready handshake, last flag. It is reused for tag and VARINT value; the fixed-width paths share its byte output mux.

Test Plan:
- field_id=1, VARINT, size=4, offset=8, base=0x100, mem[0x108]=150 → mem_addr=0x108; bytes 08 96 01; out_last on 01; one ser_done pulse.
- field_id=2, FIXED32, mem=0x00000000DEADBEEF → bytes 15 EF BE AD DE; err=0.
- field_id=16, nested=1 → bytes 82 01; no mem_req; ser_done.
- field_id=0 → no bytes, no mem_req; ser_done within 2 cycles of acceptance.
- VARINT value 0xFFFFFFFFFFFFFFFF, size=8, out_ready low 3 cycles mid-stream → 10 bytes (9×FF then 01); held byte stable; none lost or duplicated.
- reset_n low during MEM_WAIT, stale mem_rvalid after release → outputs 0 immediately; rvalid ignored; ser_ready=1; next entry serializes correctly.
